// File: rtl/cr_structs.sv
// Shared stream types and arbiter constants for the TLVP outbound path.
package cr_structs;

    localparam int unsigned TDATA_W    = 64;
    localparam int unsigned TKEEP_W    = 8;
    localparam int unsigned GRANT_W    = 3;
    localparam int unsigned BEAT_CNT_W = 12;

    typedef struct packed {
        logic               tvalid;
        logic [TDATA_W-1:0] tdata;
        logic [TKEEP_W-1:0] tkeep;
        logic               tlast;
    } axi4s_dp_bus_t;

    typedef struct packed {
        logic tready;
    } axi4s_dp_rdy_t;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

endpackage

// File: rtl/cr_tlvp_ob_arb_if.sv
// Requester FIFO side and merged output stream of the outbound arbiter.
interface cr_tlvp_ob_arb_if #(
    parameter int unsigned N_REQ = 4
);
    import cr_structs::*;

    logic [N_REQ-1:0]   req_empty;
    axi4s_dp_bus_t      req_data [N_REQ];
    logic [N_REQ-1:0]   req_rd;
    axi4s_dp_rdy_t      axi4s_ob_in;
    axi4s_dp_bus_t      axi4s_ob_out;
    logic [GRANT_W-1:0] grant_id;
    logic               busy;
    logic               len_err;

    modport master (
        input  req_empty, req_data, axi4s_ob_in,
        output req_rd, axi4s_ob_out, grant_id, busy, len_err
    );

    modport slave (
        output req_empty, req_data, axi4s_ob_in,
        input  req_rd, axi4s_ob_out, grant_id, busy, len_err
    );

endinterface

// File: rtl/cr_tlvp_ob_arb_rr_pick.sv
// Rotating-priority search: first set request at or above rr_ptr, wrapping.
module cr_tlvp_rr_pick
    import cr_structs::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [GRANT_W-1:0] rr_ptr,
    output logic [GRANT_W-1:0] idx,
    output logic               found
);

    logic [2*N_REQ-1:0] dbl;
    logic [2*N_REQ-1:0] rot;
    logic [3:0]         sum;

    always_comb begin
        dbl   = {req, req};
        rot   = dbl >> rr_ptr;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        // scan downward so the smallest offset from rr_ptr wins
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = 4'(rr_ptr) + 4'(k);
                if (sum >= 4'(N_REQ)) begin
                    sum = sum - 4'(N_REQ);
                end
                idx   = GRANT_W'(sum);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cr_tlvp_ob_arb.sv
// Frame-atomic round-robin merge of N_REQ requester FIFOs onto one AXI4-Stream.
module cr_tlvp_ob_arb
    import cr_structs::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned MAX_BEATS = 1024
) (
    input  logic            clk,
    input  logic            rst,
    cr_tlvp_ob_arb_if.master ob
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e              state_q, state_d;
    logic [GRANT_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [GRANT_W-1:0]      grant_q, grant_d;
    logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic                    busy_q, busy_d;
    logic                    len_err_q, len_err_d;
    axi4s_dp_bus_t           out_q, out_d;

    logic [GRANT_W-1:0]      pick_idx;
    logic                    pick_found;
    logic [IDX_W-1:0]        g_sel;
    logic                    pop_c;
    logic [N_REQ-1:0]        req_rd_c;

    cr_tlvp_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (~ob.req_empty),
        .rr_ptr (rr_ptr_q),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    assign g_sel = grant_q[IDX_W-1:0];

    // Pop the owner's FIFO whenever the output register is free or draining.
    always_comb begin
        pop_c    = (state_q == XFER) && !rst && !ob.req_empty[g_sel] &&
                   (!out_q.tvalid || ob.axi4s_ob_in.tready);
        req_rd_c = '0;
        if (pop_c) begin
            req_rd_c[g_sel] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        len_err_d  = 1'b0;
        out_d      = out_q;

        if (out_q.tvalid && ob.axi4s_ob_in.tready) begin
            out_d.tvalid = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = XFER;
                end
            end
            XFER: begin
                if (pop_c) begin
                    out_d        = ob.req_data[g_sel];
                    out_d.tvalid = 1'b1;
                    // saturate at the guard so an overlong frame flags only once
                    if (beat_cnt_q != BEAT_CNT_W'(MAX_BEATS)) begin
                        beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
                    end
                    if (beat_cnt_q == BEAT_CNT_W'(MAX_BEATS - 1) && !ob.req_data[g_sel].tlast) begin
                        len_err_d = 1'b1;
                    end
                    if (ob.req_data[g_sel].tlast) begin
                        state_d  = IDLE;
                        rr_ptr_d = (grant_q == GRANT_W'(N_REQ - 1)) ? '0 : grant_q + GRANT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // busy covers the owned frame until its last beat leaves the output register
        busy_d = (state_d == XFER) || out_d.tvalid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
            busy_q     <= 1'b0;
            len_err_q  <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            busy_q     <= busy_d;
            len_err_q  <= len_err_d;
            out_q      <= out_d;
        end
    end

    assign ob.req_rd       = req_rd_c;
    assign ob.axi4s_ob_out = out_q;
    assign ob.grant_id     = grant_q;
    assign ob.busy         = busy_q;
    assign ob.len_err      = len_err_q;

endmodule

// File: doc/cr_tlvp_ob_arb.md
CR_TLVP_OB_ARB -- requirements
Module: cr_tlvp_ob_arb

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requester streams (2..8).
REQ-002 Parameter MAX_BEATS, default 1024, SHALL set the frame-length guard in beats.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL be updated on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 req_empty  input  N_REQ  SHALL be the per-requester FIFO empty flags.
REQ-006 req_data  input  N_REQ x axi4s_dp_bus_t  SHALL be the per-requester FIFO head beats, valid while the matching req_empty is 0.
REQ-007 req_rd  output  N_REQ  SHALL be the per-requester FIFO pop strobes.
REQ-008 axi4s_ob_in  input  axi4s_dp_rdy_t  SHALL carry downstream tready.
REQ-009 axi4s_ob_out  output  axi4s_dp_bus_t  SHALL be the merged output stream.
REQ-010 grant_id  output  3  SHALL be the index of the current owner; valid while busy=1.
REQ-011 busy  output  1  SHALL be 1 while a frame is owned (state XFER).
REQ-012 len_err  output  1  SHALL be a one-cycle pulse flagging a frame that exceeds MAX_BEATS.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and XFER.
REQ-014 In IDLE, the arbiter SHALL pick the first index i with req_empty[i]=0, searching from rr_ptr upward with wrap-around modulo N_REQ.
REQ-015 In IDLE, the grant SHALL be latched into grant_id and the FSM SHALL enter XFER on the next edge; no req_rd SHALL assert in IDLE.
REQ-016 In XFER, req_rd[g] SHALL assert only when req_empty[g]=0 and (axi4s_ob_out.tvalid=0 or tready=1).
REQ-017 All req_rd bits other than the granted index g SHALL be 0.
REQ-018 On each req_rd[g], req_data[g] SHALL load the output register; tvalid SHALL be 1 on the following cycle.
REQ-019 The output register SHALL hold tvalid and all other fields stable while tvalid=1 and tready=0.
REQ-020 The output register SHALL clear tvalid when it drains (tready=1) without a new load.
REQ-021 Minimum latency SHALL be two cycles: req_empty falling in IDLE at cycle 0 -> grant at cycle 1 -> tvalid at cycle 2.
REQ-022 Sustained throughput within a frame SHALL be one beat per cycle while the FIFO is non-empty and tready=1.
REQ-023 When the popped beat has tlast=1, the FSM SHALL return to IDLE on the next edge, and rr_ptr SHALL become (g+1) mod N_REQ.
REQ-024 Between frames there SHALL be at least one arbitration cycle.
REQ-025 The grant SHALL never change mid-frame; frames SHALL be atomic and unmodified.
REQ-026 A 12-bit beat counter SHALL count pops in the current frame and clear on entry to XFER.
REQ-027 When the beat counter reaches MAX_BEATS with no tlast, len_err SHALL pulse once and the counter SHALL saturate; the frame SHALL continue until tlast with no truncation.
REQ-028 If the granted FIFO goes empty mid-frame, the block SHALL stall in XFER, holding the grant, with no timeout.
REQ-029 A single requester SHALL regain the grant after each of its frames when no other requester is non-empty.

Reset
REQ-030 While rst=1, the FSM SHALL be IDLE, rr_ptr=0, beat counter=0, grant_id=0, busy=0 and len_err=0.
REQ-031 While rst=1, axi4s_ob_out SHALL be all-zero (tvalid=0) and req_rd SHALL be all-zero.
REQ-032 Reset asserted mid-frame SHALL abandon the frame with no pop in the reset cycle; the remaining beats are the requester's concern.

Structure
REQ-033 axi4s_dp_bus_t and axi4s_dp_rdy_t SHALL come from cr_structs.
REQ-034 The FSM state enum and the MAX_BEATS counter width constant SHALL be added to cr_structs.
REQ-035 The rotating-priority search SHALL be one combinational sub-module, cr_tlvp_rr_pick (inputs: request vector, rr_ptr; outputs: index, found).

Verification
REQ-036 Requester 2 only: 3-beat frame, tready=1 -> grant_id=2 at cycle 1, tvalid cycles 2-4, tlast on cycle 4, busy falls at cycle 5.
REQ-037 All four requesters with 2-beat frames, continuously non-empty -> grant order 0,1,2,3,0; never two req_rd bits high together.
REQ-038 tready=0 for 5 cycles mid-frame -> axi4s_ob_out holds the same tdata, req_rd=0 throughout, no beat lost or duplicated.
REQ-039 2000-beat frame, MAX_BEATS=1024 -> exactly one len_err pulse at the 1024th pop, all 2000 beats delivered, tlast intact.
REQ-040 rst=1 for one cycle at beat 3 of 8 -> next cycle tvalid=0, busy=0, req_rd=0, rr_ptr=0; fresh arbitration afterward.
